// File: rtl/image_proto_pkg.sv
// Constants and helpers shared by both ends of the UART image-transfer protocol.
package image_proto_pkg;

  // Protocol control bytes
  localparam logic [7:0] SOH            = 8'h01;
  localparam logic [7:0] READY          = 8'h06;
  localparam logic [7:0] ACK            = 8'h06;
  localparam logic [7:0] ETX            = 8'h03;
  localparam logic [7:0] IMAGE_RECEIVED = 8'h16;
  localparam logic [7:0] COMMA          = 8'h2C;

  // Data bytes per acknowledged chunk
  localparam int CHUNK_SIZE_DEFAULT = 256;

  // Sender state machine encoding, exported for debug observation
  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_SOH,
    S_SEND_HDR,
    S_WAIT_READY,
    S_FETCH,
    S_LOAD,
    S_SEND_BYTE,
    S_WAIT_ACK,
    S_SEND_ETX,
    S_WAIT_DONE
  } state_t;

  // Nibble to uppercase ASCII hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) return 8'h30 + n8;
    else           return 8'h37 + n8;
  endfunction

endpackage

// File: rtl/image_send_if.sv
// Frame-buffer read port plus byte-level UART TX/RX, as seen by the image sender.
//
// Handshake rules:
//   TX: a byte transfers on a cycle where tx_valid and tx_ready are both high.
//       Once tx_valid is raised, tx_valid and tx_data stay unchanged until that
//       transfer cycle; tx_ready may toggle freely and does not depend on tx_valid.
//   RX: rx_valid is a one-cycle strobe with rx_data valid in the same cycle;
//       there is no back-pressure.
//   RD: rd_data is valid exactly one cycle after a cycle with rd_en high,
//       and reflects the byte at rd_addr from the rd_en cycle.
interface image_send_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;

  // Sender side
  modport master (
    output rd_en, rd_addr, tx_data, tx_valid,
    input  rd_data, tx_ready, rx_data, rx_valid
  );

  // Frame buffer / UART side
  modport slave (
    input  rd_en, rd_addr, tx_data, tx_valid,
    output rd_data, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/image_send.sv
// Initiator of the UART image-transfer protocol: SOH, 9-byte ASCII header,
// wait READY, stream the frame buffer in acknowledged chunks, ETX, wait
// IMAGE_RECEIVED. Each response wait is bounded by a timeout.
module image_send
  import image_proto_pkg::*;
#(
  parameter int          CHUNK_SIZE     = CHUNK_SIZE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 27000000,
  parameter int          ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_size,
  input  logic [15:0]       img_checksum,
  image_send_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_t            dbg_state
);

  localparam int CW = $clog2(CHUNK_SIZE) + 1;
  localparam int TW = 27;
  localparam logic [CW-1:0] CHUNK_FULL = CW'(CHUNK_SIZE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    HDR_LAST   = 4'd8;

  state_t            state;
  logic [ADDR_W-1:0] size_q;
  logic [15:0]       cks_q;
  logic [ADDR_W-1:0] byte_cnt;
  logic [CW-1:0]     chunk_cnt;
  logic [3:0]        hdr_idx;
  logic [TW-1:0]     tmo_cnt;

  logic              tx_fire;
  logic              rx_ready_hit;
  logic              rx_ack_hit;
  logic              rx_done_hit;
  logic              tmo_hit;
  logic              all_sent;
  logic [ADDR_W-1:0] byte_next;
  logic [CW-1:0]     chunk_next;
  logic [15:0]       size16;

  // Header byte i: 4 hex digits of size, comma, 4 hex digits of checksum
  function automatic logic [7:0] hdr_byte(input logic [3:0] i,
                                          input logic [15:0] sz,
                                          input logic [15:0] ck);
    logic [7:0] b;
    case (i)
      4'd0:    b = nib2hex(sz[15:12]);
      4'd1:    b = nib2hex(sz[11:8]);
      4'd2:    b = nib2hex(sz[7:4]);
      4'd3:    b = nib2hex(sz[3:0]);
      4'd4:    b = COMMA;
      4'd5:    b = nib2hex(ck[15:12]);
      4'd6:    b = nib2hex(ck[11:8]);
      4'd7:    b = nib2hex(ck[7:4]);
      4'd8:    b = nib2hex(ck[3:0]);
      default: b = COMMA;
    endcase
    return b;
  endfunction

  // Handshake, response-match and counter-step decodes
  always_comb begin
    tx_fire      = bus.tx_valid & bus.tx_ready;
    rx_ready_hit = bus.rx_valid && (bus.rx_data == READY);
    rx_ack_hit   = bus.rx_valid && (bus.rx_data == ACK);
    rx_done_hit  = bus.rx_valid && (bus.rx_data == IMAGE_RECEIVED);
    tmo_hit      = (tmo_cnt == TMO_LAST);
    all_sent     = (byte_cnt == size_q);
    byte_next    = byte_cnt + 1'b1;
    chunk_next   = chunk_cnt + 1'b1;
    size16       = 16'(size_q);
  end

  assign dbg_state = state;

  // Main sequencer: all outputs registered; done/error/rd_en are single-cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      size_q       <= '0;
      cks_q        <= '0;
      byte_cnt     <= '0;
      chunk_cnt    <= '0;
      hdr_idx      <= '0;
      tmo_cnt      <= '0;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      bus.rd_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            size_q       <= img_size;
            cks_q        <= img_checksum;
            byte_cnt     <= '0;
            chunk_cnt    <= '0;
            hdr_idx      <= '0;
            tmo_cnt      <= '0;
            busy         <= 1'b1;
            bus.tx_data  <= SOH;
            bus.tx_valid <= 1'b1;
            state        <= S_SEND_SOH;
          end
        end

        S_SEND_SOH: begin
          // First header byte follows SOH back-to-back
          if (tx_fire) begin
            hdr_idx     <= '0;
            bus.tx_data <= hdr_byte(4'd0, size16, cks_q);
            state       <= S_SEND_HDR;
          end
        end

        S_SEND_HDR: begin
          if (tx_fire) begin
            if (hdr_idx == HDR_LAST) begin
              bus.tx_valid <= 1'b0;
              tmo_cnt      <= '0;
              state        <= S_WAIT_READY;
            end else begin
              hdr_idx     <= hdr_idx + 4'd1;
              bus.tx_data <= hdr_byte(hdr_idx + 4'd1, size16, cks_q);
            end
          end
        end

        S_WAIT_READY: begin
          if (rx_ready_hit) begin
            if (all_sent) begin
              bus.tx_data  <= ETX;
              bus.tx_valid <= 1'b1;
              state        <= S_SEND_ETX;
            end else begin
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= byte_cnt;
              state       <= S_FETCH;
            end
          end else if (tmo_hit) begin
            error        <= 1'b1;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_FETCH: begin
          // rd_en is high during this cycle; data arrives next cycle
          state <= S_LOAD;
        end

        S_LOAD: begin
          bus.tx_data  <= bus.rd_data;
          bus.tx_valid <= 1'b1;
          state        <= S_SEND_BYTE;
        end

        S_SEND_BYTE: begin
          if (tx_fire) begin
            byte_cnt     <= byte_next;
            bus.tx_valid <= 1'b0;
            if (chunk_next == CHUNK_FULL) begin
              chunk_cnt <= '0;
              tmo_cnt   <= '0;
              state     <= S_WAIT_ACK;
            end else begin
              chunk_cnt <= chunk_next;
              if (byte_next == size_q) begin
                bus.tx_data  <= ETX;
                bus.tx_valid <= 1'b1;
                state        <= S_SEND_ETX;
              end else begin
                bus.rd_en   <= 1'b1;
                bus.rd_addr <= byte_next;
                state       <= S_FETCH;
              end
            end
          end
        end

        S_WAIT_ACK: begin
          // A full final chunk is acknowledged before ETX
          if (rx_ack_hit) begin
            if (all_sent) begin
              bus.tx_data  <= ETX;
              bus.tx_valid <= 1'b1;
              state        <= S_SEND_ETX;
            end else begin
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= byte_cnt;
              state       <= S_FETCH;
            end
          end else if (tmo_hit) begin
            error        <= 1'b1;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_SEND_ETX: begin
          if (tx_fire) begin
            bus.tx_valid <= 1'b0;
            tmo_cnt      <= '0;
            state        <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (rx_done_hit) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmo_hit) begin
            error        <= 1'b1;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          bus.tx_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_send.sv
// Directed-plus-random bench for image_send: a frame-buffer model, a TX byte
// monitor and a reference byte stream built from the protocol rules.
module tb_image_send;
  import image_proto_pkg::*;

  localparam int TMO = 1000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] img_size;
  logic [15:0] img_checksum;
  logic        busy;
  logic        done;
  logic        error;
  state_t      dut_state;

  image_send_if #(.ADDR_W(16)) bus ();

  image_send #(
    .CHUNK_SIZE    (256),
    .TIMEOUT_CYCLES(TMO),
    .ADDR_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .img_size    (img_size),
    .img_checksum(img_checksum),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .dbg_state   (dut_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  logic [15:0] addr_q [$];

  bit rand_ready = 1'b0;
  bit hold_low   = 1'b0;

  string hexd = "0123456789ABCDEF";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- frame buffer model ----------------
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[9:0]];
  end

  // ---------------- tx_ready driver ----------------
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low)        bus.tx_ready = 1'b0;
      else if (rand_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
      else                 bus.tx_ready = 1'b1;
    end
  end

  // ---------------- TX / status monitor ----------------
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.rd_en) addr_q.push_back(bus.rd_addr);
      if (done) done_cnt++;
      if (error) err_cnt++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [15:0] sz, input logic [15:0] ck);
    @(posedge clk); #1;
    img_size = sz; img_checksum = ck; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int budget = 30000;
    while (got_q.size() < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk(tag, 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic quiet(input int n, input string tag);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic fill_mem(input int size);
    logic [7:0] b;
    for (int i = 0; i < size; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h03);
      mem[i] = b;
    end
  endtask

  // Reference stream: SOH, hex(size) ',' hex(cks), image bytes, ETX
  task automatic build_exp(input int size, input logic [15:0] ck);
    exp_q.delete();
    exp_q.push_back(8'h01);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[(size >> (4 * i)) & 15]);
    exp_q.push_back(8'h2C);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[(int'(ck) >> (4 * i)) & 15]);
    for (int i = 0; i < size; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(8'h03);
  endtask

  task automatic compare_streams(input int size);
    int n;
    chk("stream_len", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    chk("addr_len", 64'(addr_q.size()), 64'(size));
    for (int i = 0; i < addr_q.size() && i < size; i++)
      chk($sformatf("addr%0d", i), 64'(addr_q[i]), 64'(i));
  endtask

  // Full successful transfer with the receiver's replies
  task automatic run_xfer(input int size, input logic [15:0] ck,
                          input bit hdr_stall, input bit stray, input bit restart);
    int sent, chunk, done_base, err_base;
    fill_mem(size);
    build_exp(size, ck);
    got_q.delete(); addr_q.delete();
    done_base = done_cnt; err_base = err_cnt;
    pulse_start(16'(size), ck);
    chk("busy_rise", 64'(busy), 64'd1);
    if (hdr_stall) begin
      wait_bytes(4, "hdr_part");
      hold_low = 1'b1;
      repeat (20) @(posedge clk);
      #1 hold_low = 1'b0;
    end
    wait_bytes(10, "hdr_sent");
    if (restart) pulse_start(16'h0003, 16'hFFFF);
    quiet(8, "wait_ready_quiet");
    send_rx(8'h06);
    sent = 0;
    while (sent < size) begin
      chunk = (size - sent > 256) ? 256 : size - sent;
      sent += chunk;
      wait_bytes(10 + sent, "chunk_sent");
      if (chunk == 256) begin
        quiet(8, "ack_stall");
        if (stray) begin
          send_rx(8'h41);
          quiet(6, "stray_ignored");
        end
        send_rx(8'h06);
      end
    end
    wait_bytes(11 + size, "etx_sent");
    quiet(8, "wait_done_quiet");
    send_rx(8'h16);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 64'(done_cnt - done_base), 64'd1);
    chk("no_error", 64'(err_cnt - err_base), 64'd0);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("idle_state", 64'(dut_state), 64'(S_IDLE));
    compare_streams(size);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, err_base, sz_before, budget;
    reset = 1'b1; start = 1'b0; img_size = '0; img_checksum = '0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bus.rd_en, bus.rd_addr, bus.tx_valid, bus.tx_data, busy, done, error}, 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", 64'(dut_state), 64'(S_IDLE));

    // Small image, always-ready UART
    run_xfer(5, 16'h00AB, 1'b0, 1'b0, 1'b0);
    chk("hdr_literal", {got_q[1], got_q[2], got_q[3], got_q[4], got_q[5]}, 64'h303030352C);

    rand_ready = 1'b1;
    // Two full chunks: ACK after each, including the last
    run_xfer(512, 16'($urandom), 1'b0, 1'b0, 1'b0);
    // Full chunk then one byte with no final ACK; start while busy ignored
    run_xfer(257, 16'($urandom), 1'b0, 1'b0, 1'b1);
    // Empty image: READY then directly ETX
    run_xfer(0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    // Header stall and stray byte during the ACK wait
    run_xfer(300, 16'($urandom), 1'b1, 1'b1, 1'b0);

    // Timeout waiting for READY
    got_q.delete(); addr_q.delete();
    err_base = err_cnt;
    pulse_start(16'h0005, 16'h1234);
    wait_bytes(10, "tmo_hdr");
    @(posedge clk);
    n = 0;
    budget = 3 * TMO;
    while (budget > 0) begin
      @(posedge clk);
      n++;
      @(negedge clk); #1;
      if (error) break;
      budget--;
    end
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_state", 64'(dut_state), 64'(S_IDLE));
    quiet(30, "tmo_no_tx");
    chk("tmo_err_once", 64'(err_cnt - err_base), 64'd1);
    chk("tmo_bytes", 64'(got_q.size()), 64'd10);

    // Reset mid-transfer during SEND_BYTE
    fill_mem(300);
    got_q.delete(); addr_q.delete();
    pulse_start(16'd300, 16'h5A5A);
    wait_bytes(10, "rst_hdr");
    send_rx(8'h06);
    budget = 5000;
    while (!(dut_state == S_SEND_BYTE && got_q.size() >= 30) && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("rst_reach_send", 64'(dut_state), 64'(S_SEND_BYTE));
    reset = 1'b1;
    #1;
    chk("rst_async_outs", {bus.rd_en, bus.rd_addr, bus.tx_valid, bus.tx_data, busy, done, error}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    sz_before = got_q.size();
    quiet(10, "rst_no_tx");
    chk("rst_no_bytes", 64'(got_q.size()), 64'(sz_before));
    run_xfer(7, 16'($urandom), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait escapes its bound
  initial begin
    #5000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/image_send.md
Name: image_send

Overview:
- Initiator side of the UART image-transfer protocol. Streams an image from a byte-addressed frame buffer to a remote receiver.
- Sequence: SOH, ASCII header, wait READY, 256-byte chunks each acknowledged, ETX, wait IMAGE_RECEIVED.
- Sits between the frame-buffer read port and a byte-level UART wrapper (valid/ready TX, strobe RX). Used for board-to-board or FPGA-to-host loopback of images.

Parameters:
- CHUNK_SIZE, 256, data bytes per acknowledged chunk.
- TIMEOUT_CYCLES, 27000000, max clk cycles waiting for any response byte (1 s at 27 MHz).
- ADDR_W, 16, frame-buffer address and size width.

Ports:
- clk  in  1  system clock, 27 MHz
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin transfer (ignored unless idle)
- img_size  in  ADDR_W  byte count, sampled on accepted start
- img_checksum  in  16  checksum value placed in header, sampled on accepted start
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_W  frame-buffer byte address
- rd_data  in  8  read data, valid exactly 1 cycle after rd_en
- tx_data  out  8  byte to UART
- tx_valid  out  1  held until tx_ready is high on the same cycle
- tx_ready  in  1  UART accepts byte when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Protocol constants: SOH 0x01, READY/ACK 0x06, ETX 0x03, IMAGE_RECEIVED 0x16, comma 0x2C.
- Header format: 4 uppercase hex ASCII digits of img_size, MSN first; then ',' (0x2C); then 4 hex digits of img_checksum. 9 bytes total. Digits 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- Reset values: rd_en=0, rd_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, error=0. State goes to IDLE and all counters clear.
- States and transitions:
  - IDLE: on start, latch size and checksum, clear counters, go to SEND_SOH.
  - SEND_SOH: present 0x01; on handshake go to SEND_HDR.
  - SEND_HDR: present header byte[idx]; idx 0..8; after byte 8 handshakes go to WAIT_READY.
  - WAIT_READY: on rx_valid with 0x06, go to FETCH if size>0, else SEND_ETX.
  - FETCH: rd_en=1 for one cycle with rd_addr=byte_cnt; go to LOAD.
  - LOAD: register rd_data into tx_data, set tx_valid, go to SEND_BYTE.
  - SEND_BYTE: on handshake, increment byte_cnt and chunk_cnt, then:
    - if chunk_cnt reaches CHUNK_SIZE: clear chunk_cnt, go to WAIT_ACK;
    - else if byte_cnt == size: go to SEND_ETX;
    - else go to FETCH.
  - WAIT_ACK: on rx 0x06, go to SEND_ETX if byte_cnt == size, else FETCH. A full final chunk is therefore ACKed before ETX; a partial final chunk is not.
  - SEND_ETX: present 0x03; on handshake go to WAIT_DONE.
  - WAIT_DONE: on rx 0x16, pulse done, go to IDLE.
- Handshake rules:
  - tx_data must be stable while tx_valid=1 and tx_ready=0.
  - tx_valid drops in the cycle after acceptance unless a new byte is presented immediately (SEND_SOH -> SEND_HDR, and consecutive header bytes).
  - Per-byte data throughput is 3 cycles minimum (FETCH, LOAD, SEND_BYTE).
- Response waits (WAIT_READY, WAIT_ACK, WAIT_DONE):
  - rx bytes other than the expected value are ignored.
  - rx_valid outside these states is ignored.
  - The timeout counter clears on entry to each wait state. If it reaches TIMEOUT_CYCLES: pulse error, drop tx_valid, go to IDLE.
- start while busy is ignored. Reset mid-transfer aborts immediately with no further bytes sent.
- Counter widths:
  - byte_cnt is ADDR_W wide. Size 0xFFFF is legal; no wrap occurs because completion is checked by equality.
  - chunk_cnt is clog2(CHUNK_SIZE)+1 bits.
  - Timeout counter is 27 bits.
- Data bytes are sent verbatim, with no escaping. Image content must not contain 0x03; this is a known protocol limitation and is not checked.

Decomposition:
- Shared package image_proto_pkg holds SOH/READY/ACK/ETX/IMAGE_RECEIVED/COMMA constants, the CHUNK_SIZE default, and a nibble-to-ASCII-hex function. The receiver is to be migrated to this package.
- A sub-module is not needed; the header formatter is a 9-way mux over latched fields.

Test Plan:
- Size 0x0005, checksum 0x00AB, reply 0x06 after header -> TX "01 30 30 30 35 2C 30 30 41 42", then 5 buffer bytes, then 03. Reply 16 -> done pulses once, busy falls.
- Size 0x0200 (512) -> after byte 256 transmitter stalls with no tx_valid until 06 arrives. After byte 512 it waits for 06 again, then sends 03.
- Size 0x0101 (257) -> ACK wait after byte 256; byte 257 sent; then 03 with no ACK wait.
- No reply after header for TIMEOUT_CYCLES (set to 1000) -> error pulses at cycle 1000 of WAIT_READY, state IDLE, no further TX.
- tx_ready held low 20 cycles mid-header, plus a stray rx 0x41 during WAIT_ACK -> tx_data stable throughout, stray byte ignored, sequence unchanged.
- Assert reset during SEND_BYTE of size 300, then start again -> outputs return to reset values immediately, and the new transfer begins with SOH and rd_addr 0.
